// File: rtl/score_tracker_if.sv
// Command/score bundle between the Simon game controller and the score tracker.
// The controller drives the round pulses; the tracker drives the display-side values.
interface score_tracker_if;
  logic       start;
  logic       advance;
  logic       fail;
  logic [5:0] num;
  logic       blank;
  logic       win;
  logic       lose;
  logic       busy;

  modport master (
    output start, advance, fail,
    input  num, blank, win, lose, busy
  );

  modport slave (
    input  start, advance, fail,
    output num, blank, win, lose, busy
  );
endinterface

// File: rtl/score_tracker.sv
// Round counter and end-of-game sequencer feeding the two-digit score display.
// Counts rounds up to MAX_ROUND, flashes the display on a win, and freezes it on a loss.
module score_tracker #(
  parameter int MAX_ROUND    = 19,
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int FLASH_COUNT  = 3
) (
  input logic           clk,
  input logic           rst,
  score_tracker_if.slave bus
);

  localparam int TIMER_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int TOG_W   = $clog2(2 * FLASH_COUNT + 1);

  localparam logic [5:0]         MAX_NUM    = 6'(MAX_ROUND);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FLASH_CYCLES - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(2 * FLASH_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    WIN_FLASH,
    DONE,
    OVER
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         num_q, num_d;
  logic               blank_q, blank_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               busy_q, busy_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TOG_W-1:0]   toggles_q, toggles_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      blank_q   <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      busy_q    <= 1'b0;
      timer_q   <= '0;
      toggles_q <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      blank_q   <= blank_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      busy_q    <= busy_d;
      timer_q   <= timer_d;
      toggles_q <= toggles_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    blank_d   = blank_q;
    timer_d   = timer_q;
    toggles_d = toggles_q;

    if (bus.start) begin
      state_d   = PLAY;
      num_d     = '0;
      blank_d   = 1'b0;
      timer_d   = '0;
      toggles_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          num_d = '0;
        end
        PLAY: begin
          // fail outranks advance, so a simultaneous pair never scores
          if (bus.fail) begin
            state_d = OVER;
          end else if (bus.advance) begin
            num_d = num_q + 6'd1;
            if (num_d == MAX_NUM) begin
              state_d   = WIN_FLASH;
              blank_d   = 1'b1;
              timer_d   = '0;
              toggles_d = '0;
            end
          end
        end
        WIN_FLASH: begin
          num_d = MAX_NUM;
          if (timer_q == TIMER_LAST) begin
            timer_d   = '0;
            blank_d   = ~blank_q;
            toggles_d = toggles_q + 1'b1;
            if (toggles_d == TOG_LAST) begin
              blank_d = 1'b0;
              state_d = DONE;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        DONE: begin
          num_d   = MAX_NUM;
          blank_d = 1'b0;
        end
        OVER: begin
        end
        default: begin
          state_d = IDLE;
          num_d   = '0;
          blank_d = 1'b0;
        end
      endcase
    end

    // flags follow the next state so they line up with the state register
    win_d  = (state_d == DONE);
    lose_d = (state_d == OVER);
    busy_d = (state_d == PLAY) || (state_d == WIN_FLASH);
  end

  assign bus.num   = num_q;
  assign bus.blank = blank_q;
  assign bus.win   = win_q;
  assign bus.lose  = lose_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed vector bench for score_tracker with MAX_ROUND=5, FLASH_CYCLES=4, FLASH_COUNT=2.
// Table-driven single-cycle vectors plus hand-written flash sequences and a random bound check.
module tb_score_tracker;

  localparam int MAX_ROUND    = 5;
  localparam int FLASH_CYCLES = 4;
  localparam int FLASH_COUNT  = 2;
  localparam int FLASH_LEN    = 2 * FLASH_COUNT * FLASH_CYCLES;

  typedef struct packed {
    logic [5:0] num;
    logic       blank;
    logic       win;
    logic       lose;
    logic       busy;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  start;
    logic  advance;
    logic  fail;
    outs_t exp;
  } vec_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  score_tracker_if sif ();

  score_tracker #(
    .MAX_ROUND   (MAX_ROUND),
    .FLASH_CYCLES(FLASH_CYCLES),
    .FLASH_COUNT (FLASH_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input int n, input logic b, input logic w, input logic l, input logic y);
    outs_t o;
    o.num   = 6'(n);
    o.blank = b;
    o.win   = w;
    o.lose  = l;
    o.busy  = y;
    return o;
  endfunction

  task automatic apply_stimulus(input logic r, input logic s, input logic a, input logic f);
    rst         = r;
    sif.start   = s;
    sif.advance = a;
    sif.fail    = f;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    sif.start   = 1'b0;
    sif.advance = 1'b0;
    sif.fail    = 1'b0;
  endtask

  task automatic check_output(input string name, input outs_t exp);
    outs_t act;
    act = {sif.num, sif.blank, sif.win, sif.lose, sif.busy};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got num=%0d blank=%b win=%b lose=%b busy=%b, want num=%0d blank=%b win=%b lose=%b busy=%b",
               name, act.num, act.blank, act.win, act.lose, act.busy,
               exp.num, exp.blank, exp.win, exp.lose, exp.busy);
    end
  endtask

  // The winning advance has just been sampled; walk the whole flash and DONE entry.
  task automatic check_flash(input string name);
    outs_t e;
    check_output({name, "_enter"}, mk(MAX_ROUND, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= FLASH_LEN; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      e = mk(MAX_ROUND, (k < FLASH_LEN) && (((k / FLASH_CYCLES) % 2) == 0),
             k == FLASH_LEN, 1'b0, k < FLASH_LEN);
      check_output($sformatf("%s_k%0d", name, k), e);
    end
  endtask

  // Score must stay within the decoder range throughout every run.
  always @(negedge clk) begin
    vectors++;
    if (sif.num > 6'(MAX_ROUND)) begin
      miscompares++;
      $display("[TB] FAIL num_bound: got num=%0d, want <= %0d", sif.num, MAX_ROUND);
    end
    assert (sif.num <= 6'(MAX_ROUND));
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[25];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    sif.start   = 1'b0;
    sif.advance = 1'b0;
    sif.fail    = 1'b0;

    //                rst   start adv   fail  num blank win lose busy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 1)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(3, 0, 0, 0, 1)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(3, 0, 0, 1, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(3, 0, 0, 1, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(3, 0, 0, 1, 0)};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1)};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1)};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 1)};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, mk(2, 0, 0, 1, 0)};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1)};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1)};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1)};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 1)};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(3, 0, 0, 0, 1)};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 1)};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0)};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0)};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0)};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 1)};
    vecs[24] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 1)};

    for (int i = 0; i < 25; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].start, vecs[i].advance, vecs[i].fail);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Full win: five back-to-back advances, then the 16-cycle flash.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < MAX_ROUND; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_output($sformatf("win_adv%0d", i), mk(i, 0, 0, 0, 1));
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_flash("flash1");

    // DONE ignores round pulses.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("done_adv", mk(MAX_ROUND, 0, 1, 0, 0));
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("done_fail", mk(MAX_ROUND, 0, 1, 0, 0));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("done_start", mk(0, 0, 0, 0, 1));

    // start during the flash while blank is high, then a fresh full flash.
    for (int i = 1; i <= MAX_ROUND; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("mid_flash", mk(MAX_ROUND, 1, 0, 0, 1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("flash_restart", mk(0, 0, 0, 0, 1));
    for (int i = 1; i <= MAX_ROUND; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_flash("flash2");

    // Reset mid-flash.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= MAX_ROUND; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("rst_flash", mk(0, 0, 0, 0, 0));

    // Random pulse stream; the negedge monitor enforces the score bound.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
